ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL provide these ports: clk_i  in  1  clock; all state updates on rising edge.
REQ-002 reset_i  in  1  synchronous, active-high reset.
REQ-003 pc_i  in  32  current program counter from the control unit.
REQ-004 inst_ready_i  in  1  consumer accepts inst_o this cycle.
REQ-005 inst_valid_o  out  1  inst_o holds a fetched instruction for the current pc_i.
REQ-006 inst_o  out  32  fetched instruction word.
REQ-007 mem_req_o  out  1  instruction memory read request.
REQ-008 mem_addr_o  out  32  word-aligned read address.
REQ-009 mem_ack_i  in  1  memory returns mem_rdata_i this cycle.
REQ-010 mem_rdata_i  in  32  read data.
REQ-011 fault_o  out  1  sticky misalignment fault; present only with IFETCH_ALIGN_CHECK_EN and tied 0 otherwise.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and HOLD.
REQ-013 IDLE: each cycle, fetch_addr <= {pc_i[31:2],2'b00}; next state BUSY.
REQ-014 In IDLE, when fault_o=1, the FSM SHALL stay in IDLE.
REQ-015 mem_req_o SHALL be 1 exactly when the state is BUSY.
REQ-016 mem_addr_o SHALL equal fetch_addr and stay stable throughout BUSY.
REQ-017 BUSY with mem_ack_i=1 and pc_i[31:2]==fetch_addr[31:2]: inst_o <= mem_rdata_i; next state HOLD.
REQ-018 BUSY with mem_ack_i=1 and a pc mismatch: discard the data; next state IDLE (stale fetch).
REQ-019 BUSY with mem_ack_i=0: remain in BUSY; wait is unbounded.
REQ-020 mem_ack_i outside BUSY SHALL be ignored.
REQ-021 inst_valid_o SHALL be 1 exactly when the state is HOLD.
REQ-022 inst_o SHALL be stable throughout HOLD.
REQ-023 HOLD with inst_ready_i=1: transfer occurs; next state IDLE.
REQ-024 HOLD with inst_ready_i=0 and pc_i[31:2]!=fetch_addr[31:2]: drop the instruction; next state IDLE (redirect).
REQ-025 HOLD with inst_ready_i=1 and a simultaneous pc change: the transfer SHALL win.
REQ-026 Latency with stable pc_i and zero-wait memory (ack in first BUSY cycle) SHALL be IDLE at cycle 0, BUSY at cycle 1, inst_valid_o=1 at cycle 2.
REQ-027 Minimum throughput SHALL be one instruction per 3 cycles.
REQ-028 The block SHALL hold at most one outstanding request and one held instruction.
REQ-029 pc_i values near 32'hFFFF_FFFC SHALL need no special handling; the block performs no address arithmetic.

Reset
REQ-030 While reset_i=1 at a clock edge, the block SHALL set state to IDLE, fetch_addr, inst_o and fault_o to 0, mem_req_o to 0 and inst_valid_o to 0.
REQ-031 Reset asserted in BUSY SHALL abandon the request; a later mem_ack_i is ignored under REQ-020.
REQ-032 Reset asserted in HOLD SHALL drop the held instruction.
REQ-033 Reset SHALL take priority over all other events.

Configuration
REQ-034 The block SHALL compile in alignment checking when IFETCH_ALIGN_CHECK_EN is defined.
REQ-035 With IFETCH_ALIGN_CHECK_EN, IDLE with pc_i[1:0]!=0 SHALL set fault_o=1 (sticky until reset) and issue no request.
REQ-036 With IFETCH_ALIGN_CHECK_EN, faults SHALL be checked only in IDLE.
REQ-037 Without IFETCH_ALIGN_CHECK_EN, pc_i[1:0] SHALL be ignored and fault_o tied to 0.

Verification
REQ-038 Reset, then pc_i=0, zero-wait memory returning 32'h0000_0001 -> mem_req_o=1 at cycle 1 with mem_addr_o=0; inst_valid_o=1 with inst_o=32'h0000_0001 at cycle 2.
REQ-039 pc_i=32'h10, ack after 4 wait cycles with rdata=32'hDEAD_BEEF -> mem_addr_o=32'h10 stable for 5 cycles, then inst_valid_o=1 and inst_o=32'hDEAD_BEEF.
REQ-040 In HOLD with inst_ready_i=0, change pc_i from 32'h10 to 32'h40 -> inst_valid_o drops next cycle; next request has mem_addr_o=32'h40.
REQ-041 In BUSY at 32'h10, change pc_i to 32'h20 before ack -> ack data discarded, inst_valid_o stays 0, next request at 32'h20.
REQ-042 In HOLD, set inst_ready_i=1 and change pc_i in the same cycle -> exactly one transfer of the held word.
REQ-043 With IFETCH_ALIGN_CHECK_EN, pc_i=32'h6 -> fault_o=1 the next cycle and stays 1; mem_req_o never asserts until reset_i pulses.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory read, one held instruction.
// Optional alignment fault when IFETCH_ALIGN_CHECK_EN is defined.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   pc_i               program counter from control unit
//   inst_ready_i       consumer accepts inst_o
//   inst_valid_o/inst_o  held instruction and its valid flag
//   mem_req_o/mem_addr_o request to instruction memory (word aligned)
//   mem_ack_i/mem_rdata_i  memory response
//   fault_o            sticky misalignment fault (0 without the macro)
module ifetch (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_i,
  input  logic        inst_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic        pc_match;

  // Word-level compare; byte offset never matters for a hit.
  assign pc_match = (pc_i[31:2] == fetch_addr_q[31:2]);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    inst_d       = inst_q;
    fault_d      = fault_q;
    unique case (state_q)
      IDLE: begin
        if (fault_q) begin
          state_d = IDLE;
`ifdef IFETCH_ALIGN_CHECK_EN
        end else if (pc_i[1:0] != 2'b00) begin
          fault_d = 1'b1;
`endif
        end else begin
          fetch_addr_d = {pc_i[31:2], 2'b00};
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          if (pc_match) begin
            inst_d  = mem_rdata_i;
            state_d = HOLD;
          end else begin
            // pc moved while waiting: response is stale
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        // transfer has priority over a redirect
        if (inst_ready_i || !pc_match) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= 32'h0;
      inst_q       <= 32'h0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_req_o    = (state_q == BUSY);
  assign mem_addr_o   = fetch_addr_q;
  assign inst_valid_o = (state_q == HOLD);
  assign inst_o       = inst_q;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign fault_o = fault_q;
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^pc_i[1:0];
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: directed scenarios plus randomized
// pc/ready/memory-latency traffic against a transaction-level model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic        inst_ready_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        fault_o;

  ifetch dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .pc_i         (pc_i),
    .inst_ready_i (inst_ready_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  item_t       exp_q[$];
  int          ncmp = 0;
  int          nerr = 0;
  int          ndeliv = 0;
  int          wait_left = 0;
  logic        req_prev = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] pc_cur = 32'h100;
  logic        r_rdy, r_rst;
  int          d0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: observe current outputs at negedge, then drive inputs
  // for the next rising edge and update the expected-item queue.
  task automatic step(input logic rst, input logic [31:0] pc,
                      input logic rdy, input logic ack,
                      input logic [31:0] data, input bit auto);
    logic rising;
    @(negedge clk);
    rising = mem_req_o && !req_prev;
    if (rising) begin
      req_addr = {pc_i[31:2], 2'b00};
      chk("req_addr", mem_addr_o, req_addr);
    end else if (mem_req_o) begin
      chk("addr_stable", mem_addr_o, req_addr);
    end
    chk("req_xor_valid", {31'b0, mem_req_o & inst_valid_o}, 32'h0);
`ifndef IFETCH_ALIGN_CHECK_EN
    chk("fault_tied", {31'b0, fault_o}, 32'h0);
`endif
    req_prev = mem_req_o;
    if (auto) begin
      data = $urandom;
      if (mem_req_o) begin
        if (rising) wait_left = $urandom_range(0, 4);
        if (wait_left == 0) ack = 1'b1;
        else begin
          ack = 1'b0;
          wait_left--;
        end
      end else begin
        ack = ($urandom_range(0, 7) == 0);
      end
    end
    reset_i      = rst;
    pc_i         = pc;
    inst_ready_i = rdy & ~rst;
    mem_ack_i    = ack;
    mem_rdata_i  = data;
    if (rst) begin
      exp_q.delete();
    end else if (ack && mem_req_o && pc[31:2] == req_addr[31:2]) begin
      chk("one_held", exp_q.size(), 32'd0);
      exp_q.push_back('{req_addr, data});
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset_i && inst_valid_o) begin
        if (exp_q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_valid: got inst_o %h, expected none",
                   inst_o);
        end else begin
          chk("inst_o", inst_o, exp_q[0].data);
          if (inst_ready_i) begin
            void'(exp_q.pop_front());
            ndeliv++;
          end else if (pc_i[31:2] != exp_q[0].addr[31:2]) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // reset and zero-wait fetch at pc 0
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, inst_valid_o}, 0);
    chk("rst_req", {31'b0, mem_req_o}, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_fault", {31'b0, fault_o}, 0);
    step(0, 0, 0, 1, 32'h1, 0);
    chk("c1_req", {31'b0, mem_req_o}, 1);
    chk("c1_addr", mem_addr_o, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c2_valid", {31'b0, inst_valid_o}, 1);
    chk("c2_inst", inst_o, 32'h1);
    step(0, 0, 1, 0, 0, 0);
    // pc 0x10 with four wait cycles
    step(0, 32'h10, 0, 0, 0, 0);
    chk("idle_after_xfer", {31'b0, inst_valid_o}, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h10, 0, 0, 0, 0);
      chk("wait_req", {31'b0, mem_req_o}, 1);
      chk("wait_addr", mem_addr_o, 32'h10);
    end
    step(0, 32'h10, 0, 1, 32'hDEAD_BEEF, 0);
    chk("ack_addr", mem_addr_o, 32'h10);
    step(0, 32'h10, 0, 0, 0, 0);
    chk("wait_valid", {31'b0, inst_valid_o}, 1);
    chk("wait_inst", inst_o, 32'hDEAD_BEEF);
    // redirect while holding
    step(0, 32'h40, 0, 0, 0, 0);
    step(0, 32'h40, 0, 0, 0, 0);
    chk("redir_drop", {31'b0, inst_valid_o}, 0);
    step(0, 32'h40, 0, 1, 32'h4444_0000, 0);
    chk("redir_addr", mem_addr_o, 32'h40);
    step(0, 32'h40, 1, 0, 0, 0);
    // stale fetch: pc changes before ack
    step(0, 32'h10, 0, 0, 0, 0);
    step(0, 32'h20, 0, 0, 0, 0);
    chk("stale_addr", mem_addr_o, 32'h10);
    step(0, 32'h20, 0, 1, 32'h5555_5555, 0);
    step(0, 32'h20, 0, 0, 0, 0);
    chk("stale_valid", {31'b0, inst_valid_o}, 0);
    chk("stale_req", {31'b0, mem_req_o}, 0);
    step(0, 32'h20, 0, 1, 32'h7777_7777, 0);
    chk("stale_next", mem_addr_o, 32'h20);
    // transfer wins over simultaneous pc change
    step(0, 32'h20, 0, 0, 0, 0);
    chk("race_valid", {31'b0, inst_valid_o}, 1);
    d0 = ndeliv;
    step(0, 32'h30, 1, 0, 0, 0);
    step(0, 32'h30, 1, 0, 0, 0);
    chk("race_once", ndeliv - d0, 1);
    chk("race_idle", {31'b0, inst_valid_o}, 0);
    // reset in BUSY, late ack ignored
    step(0, 32'h30, 0, 0, 0, 0);
    step(1, 32'h30, 0, 0, 0, 0);
    step(0, 32'h30, 0, 1, 32'hBAD0_BAD0, 0);
    chk("rstbusy_req", {31'b0, mem_req_o}, 0);
    step(0, 32'h30, 0, 0, 0, 0);
    chk("rstbusy_valid", {31'b0, inst_valid_o}, 0);
    // reset in HOLD
    step(0, 32'h30, 0, 1, 32'h1234_5678, 0);
    step(0, 32'h30, 0, 0, 0, 0);
    chk("hold_valid", {31'b0, inst_valid_o}, 1);
    step(1, 32'h30, 0, 0, 0, 0);
    step(0, 32'h30, 0, 0, 0, 0);
    chk("rsthold_valid", {31'b0, inst_valid_o}, 0);
    chk("rsthold_inst", inst_o, 0);
    // misaligned pc
    step(1, 32'h6, 0, 0, 0, 0);
    step(0, 32'h6, 0, 0, 0, 0);
    step(0, 32'h6, 0, 0, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      chk("fault_set", {31'b0, fault_o}, 1);
      chk("fault_noreq", {31'b0, mem_req_o}, 0);
      step(0, 32'h10, 0, 1, 0, 0);
    end
    step(1, 32'h10, 0, 0, 0, 0);
    step(0, 32'h10, 0, 0, 0, 0);
    chk("fault_clr", {31'b0, fault_o}, 0);
    step(0, 32'h10, 0, 0, 0, 0);
    chk("fault_req", mem_addr_o, 32'h10);
`else
    chk("misal_req", {31'b0, mem_req_o}, 1);
    chk("misal_addr", mem_addr_o, 32'h4);
`endif
    step(1, 0, 0, 0, 0, 0);
    // randomized traffic
    d0 = ndeliv;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: pc_cur = 32'h100;
          1: pc_cur = 32'h104;
          2: pc_cur = 32'h200;
          3: pc_cur = 32'hFFFF_FFFC;
          4: pc_cur = 32'h0;
          default: pc_cur = $urandom;
        endcase
`ifdef IFETCH_ALIGN_CHECK_EN
        pc_cur[1:0] = 2'b00;
`endif
      end
      r_rdy = 1'($urandom_range(0, 1));
      r_rst = ($urandom_range(0, 199) == 0);
      step(r_rst, pc_cur, r_rdy, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(0, pc_cur, 1, 0, 0, 0);
    step(0, pc_cur, 1, 0, 0, 0);
    chk("drain_empty", exp_q.size(), 0);
    chk("throughput", {31'b0, (ndeliv - d0) > 50}, 1);
    step(1, 0, 0, 0, 0, 0);
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
